// File: rtl/sdcard_apb_arbiter.sv
// Two-requester round-robin APB arbiter with per-requester lock, in front of the SD card controller.
// Optional idle-lock timeout is enabled by defining SDCARD_ARB_LOCK_TIMEOUT_EN.
module sdcard_apb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_PADDR,
  input  logic                  m0_PSEL,
  input  logic                  m0_PENABLE,
  input  logic                  m0_PWRITE,
  input  logic [31:0]           m0_PWDATA,
  input  logic                  m0_lock,
  output logic                  m0_PREADY,
  output logic [31:0]           m0_PRDATA,
  input  logic [ADDR_WIDTH-1:0] m1_PADDR,
  input  logic                  m1_PSEL,
  input  logic                  m1_PENABLE,
  input  logic                  m1_PWRITE,
  input  logic [31:0]           m1_PWDATA,
  input  logic                  m1_lock,
  output logic                  m1_PREADY,
  output logic [31:0]           m1_PRDATA,
  output logic [ADDR_WIDTH-1:0] s_PADDR,
  output logic                  s_PSEL,
  output logic                  s_PENABLE,
  output logic                  s_PWRITE,
  output logic [31:0]           s_PWDATA,
  input  logic                  s_PREADY,
  input  logic [31:0]           s_PRDATA,
  output logic                  owner,
  output logic                  locked
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state;
  logic   req0, req1;
  logic   elig0, elig1;
  logic   grant_valid, grant_id;
  logic   own_psel, own_lock;
  logic   done;

  assign req0 = m0_PSEL & m0_PENABLE;
  assign req1 = m1_PSEL & m1_PENABLE;

  // While locked only the owner may be granted; a tie goes to the requester that did not win last.
  assign elig0       = req0 & (~locked | ~owner);
  assign elig1       = req1 & (~locked | owner);
  assign grant_valid = elig0 | elig1;
  assign grant_id    = (elig0 & elig1) ? ~owner : elig1;

  assign own_psel = owner ? m1_PSEL : m0_PSEL;
  assign own_lock = owner ? m1_lock : m0_lock;

  // A requester that dropped PSEL mid-transfer gets no response; reset suppresses any pulse.
  assign done      = (state == ACCESS) & s_PREADY & ~reset;
  assign m0_PREADY = done & ~owner & m0_PSEL;
  assign m1_PREADY = done & owner & m1_PSEL;
  assign m0_PRDATA = m0_PREADY ? s_PRDATA : 32'h0;
  assign m1_PRDATA = m1_PREADY ? s_PRDATA : 32'h0;

`ifdef SDCARD_ARB_LOCK_TIMEOUT_EN
  localparam logic [15:0] TMO_MAX = 16'(LOCK_TIMEOUT);
  logic        own_req;
  logic [15:0] tmo_cnt;
  assign own_req = owner ? req1 : req0;
`else
  localparam int unused_lock_timeout = LOCK_TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      s_PSEL    <= 1'b0;
      s_PENABLE <= 1'b0;
      s_PADDR   <= '0;
      s_PWRITE  <= 1'b0;
      s_PWDATA  <= 32'h0;
      owner     <= 1'b1;
      locked    <= 1'b0;
`ifdef SDCARD_ARB_LOCK_TIMEOUT_EN
      tmo_cnt   <= 16'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner    <= grant_id;
            s_PADDR  <= grant_id ? m1_PADDR  : m0_PADDR;
            s_PWRITE <= grant_id ? m1_PWRITE : m0_PWRITE;
            s_PWDATA <= grant_id ? m1_PWDATA : m0_PWDATA;
            s_PSEL   <= 1'b1;
            state    <= SETUP;
          end
`ifdef SDCARD_ARB_LOCK_TIMEOUT_EN
          if (grant_valid) begin
            tmo_cnt <= 16'h0;
          end else if (locked && !own_req) begin
            if (tmo_cnt == TMO_MAX) locked <= 1'b0;
            else                    tmo_cnt <= tmo_cnt + 16'h1;
          end
`endif
        end
        SETUP: begin
          s_PENABLE <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (s_PREADY) begin
            s_PSEL    <= 1'b0;
            s_PENABLE <= 1'b0;
            locked    <= own_lock & own_psel;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdcard_apb_arbiter.sv
// Directed self-checking bench for sdcard_apb_arbiter: vector table of single transfers plus
// hand-written arbitration, lock, drop, reset and lock-timeout sequences.
module tb_sdcard_apb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  m0_PADDR, m1_PADDR, s_PADDR;
  logic        m0_PSEL, m0_PENABLE, m0_PWRITE, m0_lock, m0_PREADY;
  logic        m1_PSEL, m1_PENABLE, m1_PWRITE, m1_lock, m1_PREADY;
  logic [31:0] m0_PWDATA, m0_PRDATA, m1_PWDATA, m1_PRDATA;
  logic        s_PSEL, s_PENABLE, s_PWRITE, s_PREADY;
  logic [31:0] s_PWDATA, s_PRDATA;
  logic        owner, locked;

  int total = 0;
  int bad   = 0;
  int order[$];

  int          acc_cnt   = 0;
  int          slv_wait  = 0;
  logic [31:0] slv_rdata = 32'h0;

  always #5 clk = ~clk;

  // Simple slave: answers after slv_wait extra ACCESS cycles.
  assign s_PREADY = s_PSEL && s_PENABLE && (acc_cnt >= slv_wait);
  assign s_PRDATA = slv_rdata;
  always @(posedge clk) begin
    if (s_PSEL && s_PENABLE && !s_PREADY) acc_cnt <= acc_cnt + 1;
    else                                  acc_cnt <= 0;
  end

  sdcard_apb_arbiter #(.ADDR_WIDTH(5), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0_PADDR(m0_PADDR), .m0_PSEL(m0_PSEL), .m0_PENABLE(m0_PENABLE), .m0_PWRITE(m0_PWRITE),
    .m0_PWDATA(m0_PWDATA), .m0_lock(m0_lock), .m0_PREADY(m0_PREADY), .m0_PRDATA(m0_PRDATA),
    .m1_PADDR(m1_PADDR), .m1_PSEL(m1_PSEL), .m1_PENABLE(m1_PENABLE), .m1_PWRITE(m1_PWRITE),
    .m1_PWDATA(m1_PWDATA), .m1_lock(m1_lock), .m1_PREADY(m1_PREADY), .m1_PRDATA(m1_PRDATA),
    .s_PADDR(s_PADDR), .s_PSEL(s_PSEL), .s_PENABLE(s_PENABLE), .s_PWRITE(s_PWRITE),
    .s_PWDATA(s_PWDATA), .s_PREADY(s_PREADY), .s_PRDATA(s_PRDATA),
    .owner(owner), .locked(locked)
  );

  typedef struct {
    bit          m;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waitc;
    logic        exp_owner;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit m, input bit req, input bit wr, input logic [4:0] a,
                       input logic [31:0] d, input logic lk);
    if (!m) begin
      m0_PSEL = req; m0_PENABLE = req; m0_PWRITE = wr; m0_PADDR = a; m0_PWDATA = d; m0_lock = lk;
    end else begin
      m1_PSEL = req; m1_PENABLE = req; m1_PWRITE = wr; m1_PADDR = a; m1_PWDATA = d; m1_lock = lk;
    end
  endtask

  function automatic logic rdy(input bit m);
    return m ? m1_PREADY : m0_PREADY;
  endfunction

  function automatic logic [31:0] rdat(input bit m);
    return m ? m1_PRDATA : m0_PRDATA;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic do_xfer(input vec_t v);
    slv_wait  = v.waitc;
    slv_rdata = v.rdata;
    drive(v.m, 1'b1, v.wr, v.addr, v.wdata, 1'b0);
    #1;
    chk("idle_psel", s_PSEL, 0);
    step();
    chk("setup_psel", s_PSEL, 1);
    chk("setup_penable", s_PENABLE, 0);
    chk("setup_paddr", s_PADDR, v.addr);
    chk("setup_pwrite", s_PWRITE, v.wr);
    chk("setup_pwdata", s_PWDATA, v.wdata);
    chk("setup_owner", owner, v.exp_owner);
    step();
    chk("access_penable", s_PENABLE, 1);
    for (int k = 0; k < v.waitc; k++) begin
      chk("wait_pready", rdy(v.m), 0);
      step();
    end
    chk("done_pready", rdy(v.m), 1);
    chk("done_prdata", rdat(v.m), v.exp_prdata);
    chk("other_pready", rdy(!v.m), 0);
    chk("other_prdata", rdat(!v.m), 0);
    step();
    drive(v.m, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
    #1;
    chk("after_psel", s_PSEL, 0);
    chk("after_pready", rdy(v.m), 0);
    chk("after_prdata", rdat(v.m), 0);
    chk("after_locked", locked, 0);
  endtask

  // Runs n0/n1 back-to-back transfers; each requester drops its request the cycle after its last one.
  task automatic serve(input int n0, input int n1, input logic [7:0] lk0);
    int d0, d1, cyc;
    bit p0, p1;
    d0 = 0; d1 = 0; cyc = 0; p0 = 0; p1 = 0;
    order.delete();
    slv_wait = 0;
    if (n0 > 0) drive(1'b0, 1'b1, 1'b0, 5'h02, 32'h100, lk0[0]);
    if (n1 > 0) drive(1'b1, 1'b1, 1'b1, 5'h03, 32'h200, 1'b0);
    while ((d0 < n0 || d1 < n1 || p0 || p1) && cyc < 300) begin
      step();
      cyc++;
      if (p0) begin
        if (d0 >= n0) drive(1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
        else          m0_lock = lk0[d0];
        p0 = 0;
      end
      if (p1) begin
        if (d1 >= n1) drive(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
        p1 = 0;
      end
      #1;
      if (m0_PREADY || m1_PREADY) chk("one_ready", m0_PREADY & m1_PREADY, 0);
      if (m0_PREADY && d0 < n0) begin order.push_back(0); d0++; p0 = 1; end
      if (m1_PREADY && d1 < n1) begin order.push_back(1); d1++; p1 = 1; end
    end
    chk("serve_budget", (cyc < 300), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_alt[4];
    int exp_lock[5];
    int seen;
    bit pend;

    vecs[0] = '{m: 1'b0, wr: 1'b1, addr: 5'h04, wdata: 32'h12345678, rdata: 32'h0,
                waitc: 0, exp_owner: 1'b0, exp_prdata: 32'h0};
    vecs[1] = '{m: 1'b1, wr: 1'b0, addr: 5'h10, wdata: 32'h0, rdata: 32'hDEADBEEF,
                waitc: 5, exp_owner: 1'b1, exp_prdata: 32'hDEADBEEF};
    vecs[2] = '{m: 1'b0, wr: 1'b0, addr: 5'h1F, wdata: 32'h0, rdata: 32'hA5A55A5A,
                waitc: 2, exp_owner: 1'b0, exp_prdata: 32'hA5A55A5A};
    vecs[3] = '{m: 1'b1, wr: 1'b1, addr: 5'h08, wdata: 32'hCAFEF00D, rdata: 32'h0,
                waitc: 1, exp_owner: 1'b1, exp_prdata: 32'h0};
    exp_alt  = '{0, 1, 0, 1};
    exp_lock = '{0, 0, 0, 0, 1};

    drive(1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
    reset = 1'b1;
    step();
    step();
    chk("rst_psel", s_PSEL, 0);
    chk("rst_penable", s_PENABLE, 0);
    chk("rst_paddr", s_PADDR, 0);
    chk("rst_pwrite", s_PWRITE, 0);
    chk("rst_pwdata", s_PWDATA, 0);
    chk("rst_owner", owner, 1);
    chk("rst_locked", locked, 0);
    chk("rst_m0_pready", m0_PREADY, 0);
    chk("rst_m1_pready", m1_PREADY, 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) do_xfer(vecs[i]);

    // Simultaneous pairs from reset alternate 0,1,0,1
    do_reset();
    serve(1, 1, 8'h00);
    chk("alt_len1", order.size(), 2);
    for (int i = 0; i < 2; i++) if (i < order.size()) chk("alt_order", order[i], exp_alt[i]);
    serve(1, 1, 8'h00);
    chk("alt_len2", order.size(), 2);
    for (int i = 0; i < 2; i++) if (i < order.size()) chk("alt_order2", order[i], exp_alt[i + 2]);

    // m0 holds the lock for three transfers while m1 keeps requesting
    serve(4, 1, 8'h07);
    chk("lock_len", order.size(), 5);
    for (int i = 0; i < 5; i++) if (i < order.size()) chk("lock_order", order[i], exp_lock[i]);
    chk("lock_released", locked, 0);

    // Requester drops PSEL mid-transfer: no response, lock not retained
    slv_wait = 2;
    drive(1'b0, 1'b1, 1'b1, 5'h05, 32'h55, 1'b1);
    step();
    step();
    drive(1'b0, 1'b0, 1'b1, 5'h05, 32'h55, 1'b1);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("drop_pready", m0_PREADY, 0);
      step();
    end
    chk("drop_psel", s_PSEL, 0);
    chk("drop_locked", locked, 0);
    drive(1'b0, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);

    // Reset during ACCESS with the slave ready
    slv_wait = 0;
    drive(1'b1, 1'b1, 1'b0, 5'h09, 32'h0, 1'b1);
    step();
    step();
    chk("pre_rst_penable", s_PENABLE, 1);
    reset = 1'b1;
    #1;
    chk("rst_acc_pready", m1_PREADY, 0);
    step();
    chk("rst_acc_psel", s_PSEL, 0);
    chk("rst_acc_penable", s_PENABLE, 0);
    chk("rst_acc_locked", locked, 0);
    chk("rst_acc_owner", owner, 1);
    chk("rst_acc_pready2", m1_PREADY, 0);
    drive(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
    reset = 1'b0;

    // m0 locks then idles while m1 requests
    serve(1, 0, 8'h01);
    chk("idle_lock_set", locked, 1);
    drive(1'b1, 1'b1, 1'b0, 5'h0A, 32'h0, 1'b0);
    seen = 0;
    pend = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (pend) begin
        drive(1'b1, 1'b0, 1'b0, 5'h0, 32'h0, 1'b0);
        pend = 0;
      end
      #1;
      if (m1_PREADY) begin
        seen++;
        pend = 1;
      end
    end
`ifdef SDCARD_ARB_LOCK_TIMEOUT_EN
    chk("timeout_m1_granted", seen, 1);
    chk("timeout_locked", locked, 0);
    chk("timeout_owner", owner, 1);
`else
    chk("lock_m1_starved", seen, 0);
    chk("lock_still_held", locked, 1);
    chk("lock_owner", owner, 0);
    chk("lock_no_psel", s_PSEL, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdcard_apb_arbiter.md
Name: sdcard_apb_arbiter

Overview:
- Two-requester APB arbiter in front of the SD card controller's single APB slave port.
- Requester 0 is the CPU peripheral bus; requester 1 is the boot/DMA sector engine.
- Arbitration is round-robin. A per-requester lock keeps a multi-register command sequence (arg, cmd, poll, FIFO drain) atomic.
- Downstream APB control is registered; PREADY/PRDATA are passed back combinationally, gated by grant.

Parameters:
- ADDR_WIDTH, 5, APB address width (matches controller apb_PADDR).
- LOCK_TIMEOUT, 65535, cycles a lock may be held idle before forced release (only with SDCARD_ARB_LOCK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- m0_PADDR / m1_PADDR  in  ADDR_WIDTH  requester address
- m0_PSEL / m1_PSEL  in  1  requester select
- m0_PENABLE / m1_PENABLE  in  1  requester access phase
- m0_PWRITE / m1_PWRITE  in  1  requester write
- m0_PWDATA / m1_PWDATA  in  32  requester write data
- m0_lock / m1_lock  in  1  hold grant after this transfer
- m0_PREADY / m1_PREADY  out  1  transfer complete
- m0_PRDATA / m1_PRDATA  out  32  read data
- s_PADDR  out  ADDR_WIDTH  to controller
- s_PSEL, s_PENABLE, s_PWRITE  out  1  to controller
- s_PWDATA  out  32  to controller
- s_PREADY  in  1  from controller
- s_PRDATA  in  32  from controller
- owner  out  1  current/last granted requester
- locked  out  1  lock active

Behaviour:
- Reset values: s_PSEL=0, s_PENABLE=0, s_PADDR=0, s_PWRITE=0, s_PWDATA=0, m*_PREADY=0, m*_PRDATA=0, owner=1 (so m0 wins the first tie), locked=0, state=IDLE.
- A request is mN_PSEL & mN_PENABLE. Each requester holds PREADY low (waits) until its transfer completes.
- FSM states IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = requests; if locked, only the owner is eligible.
  - If both eligible: grant ~owner. Else grant the single requester.
  - On grant: latch PADDR/PWRITE/PWDATA from the winner into s_*, set owner, s_PSEL=1, go SETUP.
- SETUP: s_PENABLE=1, go ACCESS.
- ACCESS:
  - Hold until s_PREADY.
  - In that same cycle, m[owner]_PREADY=1 and m[owner]_PRDATA=s_PRDATA. The other requester's PREADY stays 0 and its PRDATA=0.
  - Next edge: s_PSEL=0, s_PENABLE=0, locked=m[owner]_lock sampled in the completion cycle, go IDLE.
- Minimum latency: request first seen at cycle T; downstream SETUP at T+1; ACCESS at T+2. With zero-wait s_PREADY, upstream PREADY is asserted at T+2. Back-to-back transfers have a 1-cycle IDLE gap.
- IDLE always has s_PSEL=0, which lets the controller's strobe-done logic re-arm between transfers.
- Requester drops PSEL mid-transfer: the downstream transfer still completes, the response is discarded, and the lock is cleared.
- Non-owner requests while locked wait indefinitely; no PREADY is issued to them.
- Reset during SETUP/ACCESS: at the next edge, return to reset values regardless of s_PREADY. The downstream transfer is abandoned (the controller sees PENABLE drop).
- A simultaneous new request from the owner in the completion cycle is not accepted until IDLE.

Optional Feature:
- Macro SDCARD_ARB_LOCK_TIMEOUT_EN.
- When defined:
  - A 16-bit counter resets to 0 on each grant and increments each IDLE cycle while locked with no owner request.
  - Reaching LOCK_TIMEOUT clears locked on the next edge; the other requester may then win.
- When undefined: the lock is held until the owner completes a transfer with lock=0. No counter is instantiated.

Test Plan:
- Single m0 write PADDR=0x04, PWDATA=0x12345678, s_PREADY tied 1 -> s_PSEL rises T+1, s_PENABLE rises T+2, m0_PREADY=1 at T+2, s_PWDATA=0x12345678, m1_PREADY=0 throughout.
- m0 and m1 request in the same cycle from reset -> m0 served first, m1 next (owner 0 then 1). A third simultaneous pair -> m0 served again, i.e. alternation.
- m1 read with s_PREADY delayed 5 cycles, s_PRDATA=0xDEADBEEF -> m1_PREADY held 0 for those 5 cycles, then m1_PRDATA=0xDEADBEEF for exactly one cycle.
- m0 with lock=1 for 3 transfers while m1 requests continuously -> all 3 m0 transfers granted first, m1 granted only after the m0 transfer with lock=0.
- Reset asserted in ACCESS -> next cycle s_PSEL=0, s_PENABLE=0, locked=0, owner=1, no PREADY pulse.
- With SDCARD_ARB_LOCK_TIMEOUT_EN and LOCK_TIMEOUT=16: m0 locks then idles while m1 requests -> m1 granted about 17 cycles later; without the macro, m1 is never granted.
